// File: rtl/uart_pkg.sv
// Shared definitions for the IO2 UART transmitter.
// Holds the transmit FSM state encoding, the status-word bit positions
// seen by software on inIO2, the control-write flag position, and the
// default bit period for a 25 MHz core clock at 115200 baud.
package uart_pkg;

  localparam int CLK_HZ           = 25000000;
  localparam int BAUD             = 115200;
  localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;  // 217

  // status word bit positions
  localparam int BUSY_B  = 15;
  localparam int EMPTY_B = 14;
  localparam int FULL_B  = 13;
  localparam int OVF_B   = 12;
  localparam int PAR_B   = 11;

  // write word: bit 15 set marks a control write rather than a data byte
  localparam int CTRL_B  = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

endpackage

// File: rtl/uart_tx_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with an occupancy counter.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, wrData     write request and data (taken when not full, or when
//                    a pop happens in the same cycle)
//   pop, rdData      read request; rdData is the current head (show-ahead)
//   full, empty      derived from count, so never ambiguous
//   count            entries held, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wrData,
  input  logic             pop,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             pushOk, popOk;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  // a pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds
  assign pushOk = push && (!full || pop);
  assign popOk  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter on the decoder's IO2 slot.
// CPU writes are queued in a byte FIFO and sent as 8N1 (8E1 when built
// with UART_TX_PARITY_EN defined) on tx, LSB first.
// Ports:
//   clk    core clock
//   reset  synchronous active-high reset; aborts any frame in flight
//   in     write word: in[15]=0 data byte in[7:0]; in[15]=1 clears overflow
//   load   one-cycle write strobe (loadIO2)
//   out    registered status: busy, empty, full, overflow, parity-enabled,
//          FIFO count in [4:0]
//   tx     serial line, idle high, driven from a flop
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out,
  output logic        tx
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  txState_t      state, nextState;
  logic [BW-1:0] baudCnt;
  logic          baudDone;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          overflow;
  logic          txNext;
  logic [15:0]   statusNext;

  logic          fPush, fPop, fFull, fEmpty;
  logic [7:0]    fHead;
  logic [CW-1:0] fCount;

  logic          ctrlWr;
  logic          unusedIn;

  assign ctrlWr   = load && in[CTRL_B];
  assign fPush    = load && !in[CTRL_B];
  assign unusedIn = ^in[14:8];
  assign baudDone = (baudCnt == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
  logic parBit;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (fPush),
    .wrData (in[7:0]),
    .pop    (fPop),
    .rdData (fHead),
    .full   (fFull),
    .empty  (fEmpty),
    .count  (fCount)
  );

  // next state, FIFO pop and the level tx takes at the next edge.
  // tx is registered from the current state, so the line lags the FSM
  // by one cycle but every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    nextState = state;
    fPop      = 1'b0;
    txNext    = 1'b1;
    case (state)
      IDLE: begin
        txNext = 1'b1;
        if (!fEmpty) begin
          fPop      = 1'b1;
          nextState = START;
        end
      end
      START: begin
        txNext = 1'b0;
        if (baudDone) nextState = DATA;
      end
      DATA: begin
        txNext = shiftReg[0];
        if (baudDone && bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          nextState = PARITY;
`else
          nextState = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txNext = parBit;
        if (baudDone) nextState = STOP;
      end
`endif
      STOP: begin
        txNext = 1'b1;
        if (baudDone) begin
          // chain straight into the next frame when more data is queued
          if (!fEmpty) begin
            fPop      = 1'b1;
            nextState = START;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    statusNext          = '0;
    statusNext[BUSY_B]  = (state != IDLE);
    statusNext[EMPTY_B] = fEmpty;
    statusNext[FULL_B]  = fFull;
    statusNext[OVF_B]   = overflow;
`ifdef UART_TX_PARITY_EN
    statusNext[PAR_B]   = 1'b1;
`endif
    statusNext[4:0]     = 5'(fCount);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      overflow <= 1'b0;
      tx       <= 1'b1;
      out      <= 16'h4000;
    end else begin
      state <= nextState;
      tx    <= txNext;
      out   <= statusNext;

      // restart the bit timer on every state entry and every bit boundary
      if (state == IDLE || nextState != state || baudDone) baudCnt <= '0;
      else                                                 baudCnt <= baudCnt + 1'b1;

      if (fPop) begin
        shiftReg <= fHead;
        bitIdx   <= '0;
      end else if (state == DATA && baudDone) begin
        shiftReg <= {1'b0, shiftReg[7:1]};
        bitIdx   <= bitIdx + 1'b1;
      end

      // a push into a full FIFO is only lost if no pop frees a slot
      if (ctrlWr)                          overflow <= 1'b0;
      else if (fPush && fFull && !fPop)    overflow <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // even parity captured with the byte so it is ready after bit 7
  always_ff @(posedge clk) begin
    if (reset)     parBit <= 1'b0;
    else if (fPop) parBit <= ^fHead;
  end
`endif

endmodule
